// File: rtl/wb_mem_slave_if.sv
// Wishbone classic-cycle bus bundle between one master and one slave memory.
// Signals:
//   cyc    bus cycle in progress (master)
//   stb    transfer request strobe (master)
//   we     1 = write, 0 = read (master)
//   adr    byte address, bits [1:0] ignored by the slave (master)
//   dat_w  write data (master)
//   sel    byte-lane enables, bit n covers dat[8n+7:8n] (master)
//   dat_r  read data, non-zero only while ack is high (slave)
//   ack    normal termination pulse (slave)
//   err    error termination pulse (slave)
// Handshake: a request is cyc & stb seen by an idle slave on a rising edge; the
// slave answers each accepted request with exactly one single-cycle ack or err
// pulse, and the master must drop stb during that pulse cycle unless it wants
// the next request to be sampled at the edge that ends the pulse.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_mem_slave.sv
// Wishbone classic-cycle slave memory: single-port word RAM with byte selects,
// a fixed number of wait states and an error response outside its address window.
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        asynchronous active-high reset (RAM contents are kept)
//   bus        wb_if slave modport (cyc/stb/we/adr/dat_w/sel in, dat_r/ack/err out)
//   dbg_state  current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
// Timing: request sampled at edge N -> ack/err high for the one cycle after edge
// N+1+WAIT_CYCLES. IDLE is always visited between transfers.
module wb_mem_slave #(
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter int              MEM_WORDS   = 1024,
    parameter logic [AW-1:0]   BASE_ADDR   = '0,
    parameter int              WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    wb_if.slave        bus,
    output logic [1:0] dbg_state
);
    localparam int            IW        = $clog2(MEM_WORDS);
    localparam int            NB        = DW / 8;
    localparam logic [AW-1:0] WIN_BYTES = AW'(MEM_WORDS * 4);
    localparam logic [3:0]    CNT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Captured request
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [NB-1:0] sel_q;

    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdat_q, rdat_d;

    logic [DW-1:0] mem [MEM_WORDS];

    logic          req;
    logic          cap;
    logic [AW-1:0] off_in, off_q;
    logic          hit_in, hit_q;
    logic [IW-1:0] idx_in, idx_q;

    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [DW-1:0] mem_wdat;
    logic [NB-1:0] mem_sel;

    assign req = bus.cyc & bus.stb;

    // Offset from the window base; addresses below BASE_ADDR wrap to huge
    // values and therefore miss on the same unsigned compare.
    assign off_in = bus.adr - BASE_ADDR;
    assign hit_in = off_in < WIN_BYTES;
    assign idx_in = off_in[IW+1:2];
    assign off_q  = adr_q - BASE_ADDR;
    assign hit_q  = off_q < WIN_BYTES;
    assign idx_q  = off_q[IW+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            if (cap) begin
                we_q  <= bus.we;
                adr_q <= bus.adr;
                dat_q <= bus.dat_w;
                sel_q <= bus.sel;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap      = 1'b0;
        mem_we   = 1'b0;
        mem_idx  = idx_q;
        mem_wdat = dat_q;
        mem_sel  = sel_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdat_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cap = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the edge entering RESP is the capture
                        // edge, so the write uses the live bus values.
                        state_d  = ST_RESP;
                        mem_we   = bus.we & hit_in;
                        mem_idx  = idx_in;
                        mem_wdat = bus.dat_w;
                        mem_sel  = bus.sel;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.cyc) begin
                    // Master abandoned the cycle: nothing is written or answered.
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    mem_we  = we_q & hit_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (hit_q) begin
                    ack_d = 1'b1;
                    if (!we_q) begin
                        rdat_d = mem[idx_q];
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM has no reset; a write is suppressed while rst is held.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_sel[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
                end
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.dat_r = rdat_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_wb_mem_slave.sv
module tb_wb_mem_slave;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    // Expected responses: {err, ack, data}
    logic [33:0] exp0_q[$];
    logic [33:0] exp3_q[$];
    logic        prev_ack0 = 1'b0;
    logic        prev_ack3 = 1'b0;

    logic [1:0] dbg0, dbg3;

    wb_if #(.AW(32), .DW(32)) bus0 ();
    wb_if #(.AW(32), .DW(32)) bus3 ();

    wb_mem_slave #(
        .AW(32), .DW(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0)
    );

    wb_mem_slave #(
        .AW(32), .DW(32), .MEM_WORDS(64), .BASE_ADDR(32'h400), .WAIT_CYCLES(3)
    ) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .dbg_state(dbg3)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected response whenever the DUT terminates a cycle.
    task automatic mon_one(input int which, input logic ack, input logic err,
                           input logic [31:0] dat, input logic prev_ack);
        logic [33:0] e;
        logic        empty;
        string       p;
        p = (which == 0) ? "w0" : "w3";
        check32({p, " ack_err_exclusive"}, {31'd0, ack & err}, 32'd0);
        check32({p, " ack_single_pulse"}, {31'd0, ack & prev_ack}, 32'd0);
        if (ack || err) begin
            empty = (which == 0) ? (exp0_q.size() == 0) : (exp3_q.size() == 0);
            if (empty) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s unexpected_resp: got ack=%0b err=%0b, expected none", p, ack, err);
            end else begin
                if (which == 0) e = exp0_q.pop_front();
                else            e = exp3_q.pop_front();
                check32({p, " resp_kind {err,ack}"}, {30'd0, err, ack}, {30'd0, e[33:32]});
                check32({p, " resp_data"}, dat, e[31:0]);
            end
        end else begin
            check32({p, " idle_data_zero"}, dat, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_one(0, bus0.ack, bus0.err, bus0.dat_r, prev_ack0);
            mon_one(1, bus3.ack, bus3.err, bus3.dat_r, prev_ack3);
        end
        prev_ack0 = bus0.ack;
        prev_ack3 = bus3.ack;
    end

    task automatic drive(input int which, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        if (which == 0) begin
            bus0.cyc = c; bus0.stb = s; bus0.we = w; bus0.adr = a; bus0.dat_w = d; bus0.sel = sl;
        end else begin
            bus3.cyc = c; bus3.stb = s; bus3.we = w; bus3.adr = a; bus3.dat_w = d; bus3.sel = sl;
        end
    endtask

    task automatic get_resp(input int which, output logic r);
        r = (which == 0) ? (bus0.ack | bus0.err) : (bus3.ack | bus3.err);
    endtask

    // One transfer, called at a falling edge; exp_lat counts falling edges from
    // drive to the first one that sees the response (WAIT_CYCLES + 2).
    task automatic xfer(input int which, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sl,
                        input logic exp_err, input logic [31:0] exp_dat, input int exp_lat);
        int   n;
        logic r;
        if (which == 0) exp0_q.push_back({exp_err, ~exp_err, exp_dat});
        else            exp3_q.push_back({exp_err, ~exp_err, exp_dat});
        drive(which, 1'b1, 1'b1, w, a, d, sl);
        n = 0;
        r = 1'b0;
        while (!r && n < 64) begin
            @(negedge clk);
            n++;
            get_resp(which, r);
        end
        drive(which, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        if (!r) begin
            n_tests++;
            n_fail++;
            $display("FAIL xfer_timeout: no response after %0d cycles, expected one", n);
        end else begin
            check32("latency", n, exp_lat);
        end
    endtask

    initial begin
        int   t_prev;
        int   n;
        logic r;
        logic timed_out;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(negedge clk);
        check32("rst w0 ack", {31'd0, bus0.ack}, 32'd0);
        check32("rst w0 err", {31'd0, bus0.err}, 32'd0);
        check32("rst w0 dat", bus0.dat_r, 32'd0);
        check32("rst w0 state", {30'd0, dbg0}, 32'd0);
        check32("rst w3 ack", {31'd0, bus3.ack}, 32'd0);
        check32("rst w3 err", {31'd0, bus3.err}, 32'd0);
        check32("rst w3 dat", bus3.dat_r, 32'd0);
        check32("rst w3 state", {30'd0, dbg3}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero wait states: write then read back
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 2);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 2);

        // Byte lanes: only lanes 0 and 2 take the new bytes
        xfer(0, 1'b1, 32'h20, 32'h00000000, 4'hF, 1'b0, 32'h0, 2);
        xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 2);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h00BB00DD, 2);
        // sel=0 acks but changes nothing
        xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, 2);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h00BB00DD, 2);

        // Window edges (1024 words at 0): 0x1000 misses, 0xFFC hits, no aliasing onto word 0
        xfer(0, 1'b1, 32'h0, 32'h11111111, 4'hF, 1'b0, 32'h0, 2);
        xfer(0, 1'b1, 32'hFFC, 32'h12345678, 4'hF, 1'b0, 32'h0, 2);
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b1, 32'h0, 2);
        xfer(0, 1'b1, 32'h1000, 32'h99999999, 4'hF, 1'b1, 32'h0, 2);
        xfer(0, 1'b0, 32'hFFC, 32'h0, 4'hF, 1'b0, 32'h12345678, 2);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h11111111, 2);

        // Three wait states, window 0x400..0x4FF
        xfer(1, 1'b1, 32'h404, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 5);
        xfer(1, 1'b0, 32'h404, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D, 5);
        xfer(1, 1'b1, 32'h4FC, 32'h5A5A0FF0, 4'hF, 1'b0, 32'h0, 5);
        xfer(1, 1'b0, 32'h4FC, 32'h0, 4'hF, 1'b0, 32'h5A5A0FF0, 5);
        xfer(1, 1'b0, 32'h3FC, 32'h0, 4'hF, 1'b1, 32'h0, 5);
        xfer(1, 1'b1, 32'h500, 32'h77777777, 4'hF, 1'b1, 32'h0, 5);

        // Abort: cyc dropped one cycle into WAIT -> no response, no write
        drive(1, 1'b1, 1'b1, 1'b1, 32'h404, 32'h0BADBEEF, 4'hF);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (8) @(negedge clk);
        check32("abort state idle", {30'd0, dbg3}, 32'd0);
        xfer(1, 1'b0, 32'h404, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D, 5);

        // Back-to-back: stb held through 8 reads
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b1, 32'h40 + 32'(4 * i), 32'hB0000000 + 32'(i), 4'hF, 1'b0, 32'h0, 2);
        end
        for (int i = 0; i < 8; i++) begin
            exp0_q.push_back({2'b01, 32'hB0000000 + 32'(i)});
        end
        drive(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        t_prev = 0;
        timed_out = 1'b0;
        for (int i = 0; i < 8 && !timed_out; i++) begin
            n = 0;
            r = 1'b0;
            while (!r && n < 16) begin
                @(negedge clk);
                n++;
                get_resp(0, r);
            end
            if (!r) begin
                timed_out = 1'b1;
                n_tests++;
                n_fail++;
                $display("FAIL b2b_timeout: no ack %0d after %0d cycles, expected one", i, n);
            end else begin
                if (i > 0) check32("b2b_spacing", cyc_cnt - t_prev, 32'd2);
                t_prev = cyc_cnt;
                if (i < 7) bus0.adr = 32'h40 + 32'(4 * (i + 1));
                else       drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            end
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (4) @(negedge clk);

        // Reset in the middle of WAIT: request dropped, RAM retained
        drive(1, 1'b1, 1'b1, 1'b0, 32'h4FC, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        check32("pre-rst state wait", {30'd0, dbg3}, 32'd1);
        rst = 1'b1;
        #1;
        check32("mid-rst ack", {31'd0, bus3.ack}, 32'd0);
        check32("mid-rst err", {31'd0, bus3.err}, 32'd0);
        check32("mid-rst state", {30'd0, dbg3}, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(1, 1'b0, 32'h4FC, 32'h0, 4'hF, 1'b0, 32'h5A5A0FF0, 5);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 2);

        repeat (6) @(negedge clk);
        check32("w0 queue drained", exp0_q.size(), 32'd0);
        check32("w3 queue drained", exp3_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
